xbus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as a responder (slave) on the xbus driven by the RV32I core.
- Accepts byte writes from the core into a TX FIFO, then serialises them 8N1, LSB first, on txd.
- Exposes status and baud-divisor registers.
- Reads are combinational, so the single-cycle core sees read data in the same cycle it issues the access.

---
 rtl/xbus_uart_tx.sv | 217 +++++++++++++++++++++
 tb/tb_xbus_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the xbus: TX FIFO, status and divisor registers.
// Optional interrupt output and IE register at 0xC when XBUS_UART_TX_IRQ_EN is defined.
`timescale 1ns/1ps

module xbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RSTVAL = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_as,
  input  logic        xbus_we,
  input  logic [3:0]  xbus_be,
  input  logic [31:0] xbus_addr,
  input  logic [31:0] xbus_wdata,
  output logic [31:0] xbus_rdata,
  output logic        txd
`ifdef XBUS_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_d;
  logic           pop;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [CW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count;
  logic           full, empty;
  logic           ovf_q;
  logic [15:0]    div_q;
  logic [15:0]    div_m1;

  logic           sel, wr;
  logic [1:0]     idx;
  logic           push_req, push_ok, ovf_clr;
  logic [31:0]    status;

  // Bus decode
  assign sel      = xbus_as && (xbus_addr[31:4] == BASE_ADDR[31:4]);
  assign idx      = xbus_addr[3:2];
  assign wr       = sel && xbus_we;
  assign push_req = wr && (idx == 2'd0) && xbus_be[0];
  assign ovf_clr  = wr && (idx == 2'd1) && xbus_be[0] && xbus_wdata[3];

  // Full/empty come from the pointers before this cycle's pop
  assign count   = wptr_q - rptr_q;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == CW'(0));
  assign push_ok = push_req && !full;

  // A zero divisor behaves as one clock per bit
  assign div_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

  assign status = {16'h0, 8'(count), 4'h0, ovf_q, empty, full, (state_q != IDLE)};

  logic unused_bits;
  assign unused_bits = ^{xbus_wdata[31:16], xbus_be[3:2], xbus_addr[1:0]};

`ifdef XBUS_UART_TX_IRQ_EN
  logic [1:0] ie_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_q <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (wr && (idx == 2'd3) && xbus_be[0]) ie_q <= xbus_wdata[1:0];
      irq <= (ie_q[0] && empty && (state_q == IDLE)) || (ie_q[1] && ovf_q);
    end
  end
`endif

  // Combinational read mux; zero when not selected so responders can be ORed
  always_comb begin
    xbus_rdata = 32'h0;
    if (sel && !xbus_we) begin
      case (idx)
        2'd1: xbus_rdata = status;
        2'd2: xbus_rdata = {16'h0, div_q};
`ifdef XBUS_UART_TX_IRQ_EN
        2'd3: xbus_rdata = {30'h0, ie_q};
`endif
        default: xbus_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= DIV_RSTVAL;
    end else if (wr && (idx == 2'd2)) begin
      if (xbus_be[0]) div_q[7:0]  <= xbus_wdata[7:0];
      if (xbus_be[1]) div_q[15:8] <= xbus_wdata[15:8];
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + CW'(1);
      if (pop)     rptr_q <= rptr_q + CW'(1);
      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[PW-1:0]] <= xbus_wdata[7:0];
  end

  // Shifter state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd     <= txd_d;
    end
  end

  // Shifter next state; each bit lasts div_m1+1 clocks, reloaded at every bit boundary
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q[PW-1:0]];
          cnt_d   = div_m1;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_m1;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_m1;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr_q[PW-1:0]];
            cnt_d   = div_m1;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xbus_uart_tx.sv
// Bench for xbus_uart_tx: register vector table, directed frame sequences, random traffic vs a timeline model.
`timescale 1ns/1ps

module tb_xbus_uart_tx;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [15:0] DRST  = 16'd868;

  logic        clk = 1'b0;
  logic        rst, as, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        txd;
`ifdef XBUS_UART_TX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  xbus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RSTVAL(DRST)) dut (
    .clk(clk), .rst(rst), .xbus_as(as), .xbus_we(we), .xbus_be(be),
    .xbus_addr(addr), .xbus_wdata(wdata), .xbus_rdata(rdata), .txd(txd)
`ifdef XBUS_UART_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO queue plus a frame timeline (start edge, bit period)
  logic [7:0]  q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_div = DRST;
  bit          m_active = 1'b0;
  int          m_fs = 0, m_fd = 1, ecount = 0;
  logic [7:0]  m_cur = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return 1'b1;
  endfunction

  function automatic logic m_txd();
    if (!m_active) return 1'b1;
    return frame_bit(m_cur, (ecount - m_fs) / m_fd);
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(q.size()), 4'h0, m_ovf, q.size() == 0, q.size() == DEPTH, m_active};
  endfunction

  function automatic logic [31:0] m_rdata(input logic a, input logic w, input logic [31:0] ad);
    if (!a || w || ad[31:4] != BASE[31:4]) return 32'h0;
    case (ad[3:2])
      2'd1:    return m_status();
      2'd2:    return {16'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int sz;
    int dd;
    ecount++;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_div = DRST;
      m_active = 1'b0;
      return;
    end
    sz = q.size();
    dd = (m_div == 16'd0) ? 1 : int'(m_div);
    if (m_active && (ecount - m_fs) == 10 * m_fd) begin
      if (sz > 0) begin
        m_cur = q.pop_front(); m_fs = ecount; m_fd = dd;
      end else begin
        m_active = 1'b0;
      end
    end else if (!m_active && sz > 0) begin
      m_cur = q.pop_front(); m_fs = ecount; m_fd = dd; m_active = 1'b1;
    end
    if (as && we && addr[31:4] == BASE[31:4]) begin
      case (addr[3:2])
        2'd0: if (be[0]) begin
          if (sz == DEPTH) m_ovf = 1'b1;
          else q.push_back(wdata[7:0]);
        end
        2'd1: if (be[0] && wdata[3]) m_ovf = 1'b0;
        2'd2: begin
          if (be[0]) m_div[7:0]  = wdata[7:0];
          if (be[1]) m_div[15:8] = wdata[15:8];
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_bus();
    as = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    as = 1'b1; we = 1'b1; be = b; addr = a; wdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive_wr(a, d, b);
    tick();
    idle_bus();
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    as = 1'b1; we = 1'b0; be = 4'h0; addr = a; wdata = 32'h0;
    #1;
    check(name, rdata, exp);
    idle_bus();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        as;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[17];
  int   sf_pat[10];

  initial begin
    logic [31:0] a;
    int r;
    bit stay_high;

    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0,         32'h0000_0004, "rst_status"};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h1000_0008, 32'h0,         32'h0000_0364, "rst_div"};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h1000_0000, 32'h0,         32'h0,         "txdata_rd"};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h1000_000C, 32'h0,         32'h0,         "rsvd_rd"};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'h1000_0010, 32'h0,         32'h0,         "out_of_window"};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h2000_0004, 32'h0,         32'h0,         "wrong_base"};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h1000_0004, 32'h0,         32'h0,         "as_low"};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 32'h1000_0000, 32'h55,        32'h0,         "wr_be0"};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0,         32'h0000_0004, "no_push"};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 32'h1000_000C, 32'h0,         32'h0,         "rsvd_wr"};
    vecs[10] = '{1'b1, 1'b1, 4'h1, 32'h1000_0008, 32'h0000_ABCD, 32'h0,         "div_wr_b0"};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h1000_0008, 32'h0,         32'h0000_03CD, "div_b0"};
    vecs[12] = '{1'b1, 1'b1, 4'h2, 32'h1000_0008, 32'h0000_1200, 32'h0,         "div_wr_b1"};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h1000_0008, 32'h0,         32'h0000_12CD, "div_b1"};
    vecs[14] = '{1'b1, 1'b1, 4'hF, 32'h1000_0008, 32'hFFFF_0004, 32'h0,         "div_wr_all"};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 32'h1000_0008, 32'h0,         32'h0000_0004, "div4"};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 32'h1000_0006, 32'h0,         32'h0000_0004, "status_lowbits"};
    sf_pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    idle_bus();
    do_reset();
    check("rst_txd", txd, 32'h1);

    // Register vector table
    for (int i = 0; i < 17; i++) begin
      as = vecs[i].as; we = vecs[i].we; be = vecs[i].be;
      addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check(vecs[i].name, rdata, vecs[i].exp);
      tick();
      idle_bus();
    end

    // Single frame 0xA5 at divisor 4
    wr(BASE, 32'hA5, 4'h1);
    check("sf_pre_txd", txd, 32'h1);
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("sf_txd_%0d", k), txd, 32'(sf_pat[k/4]));
      if (k == 0 || k == 20 || k == 39) rd_check("sf_busy", BASE + 32'h4, 32'h5);
    end
    tick();
    check("sf_post_txd", txd, 32'h1);
    rd_check("sf_post_status", BASE + 32'h4, 32'h4);

    // Back-to-back frames at divisor 2
    wr(BASE + 32'h8, 32'h2, 4'h3);
    drive_wr(BASE, 32'h55, 4'h1);
    tick();
    drive_wr(BASE, 32'h0F, 4'h1);
    tick();
    idle_bus();
    rd_check("b2b_count1", BASE + 32'h4, 32'h101);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      check($sformatf("b2b_txd_%0d", k), txd,
            32'(frame_bit((k < 20) ? 8'h55 : 8'h0F, (k % 20) / 2)));
      if (k == 25) rd_check("b2b_second", BASE + 32'h4, 32'h5);
    end
    tick();
    check("b2b_post_txd", txd, 32'h1);
    rd_check("b2b_post_status", BASE + 32'h4, 32'h4);

    // Overflow at divisor 100
    wr(BASE + 32'h8, 32'd100, 4'h3);
    for (int i = 0; i < 9; i++) begin
      drive_wr(BASE, 32'(i), 4'h1);
      tick();
    end
    idle_bus();
    rd_check("ovf_full", BASE + 32'h4, 32'h803);
    wr(BASE, 32'hEE, 4'h1);
    rd_check("ovf_set", BASE + 32'h4, 32'h80B);
    wr(BASE + 32'h4, 32'h8, 4'hE);
    rd_check("ovf_clr_be", BASE + 32'h4, 32'h80B);
    wr(BASE + 32'h4, 32'h8, 4'h1);
    rd_check("ovf_clr", BASE + 32'h4, 32'h803);

    // Reset during DATA of frame 0x3C with two bytes queued
    do_reset();
    wr(BASE + 32'h8, 32'h4, 4'h3);
    drive_wr(BASE, 32'h3C, 4'h1); tick();
    drive_wr(BASE, 32'h11, 4'h1); tick();
    drive_wr(BASE, 32'h22, 4'h1); tick();
    idle_bus();
    rd_check("mid_queued", BASE + 32'h4, 32'h201);
    for (int k = 0; k < 6; k++) tick();
    check("mid_data_txd", txd, 32'(frame_bit(8'h3C, 1)));
    rst = 1'b0;
    tick();
    check("mid_rst_txd", txd, 32'h1);
    rd_check("mid_rst_status", BASE + 32'h4, 32'h4);
    rd_check("mid_rst_div", BASE + 32'h8, 32'(DRST));
    rst = 1'b1;
    stay_high = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (txd !== 1'b1) stay_high = 1'b0;
    end
    check("mid_no_frames", 32'(stay_high), 32'h1);
    rd_check("mid_final_status", BASE + 32'h4, 32'h4);

    // Random traffic against the timeline model
    do_reset();
    wr(BASE + 32'h8, 32'($urandom_range(0, 3)), 4'h3);
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        drive_wr(BASE, $urandom, 4'($urandom));
      end else if (r < 55) begin
        drive_wr(BASE + 32'h4, $urandom & 32'h0000_000F, 4'($urandom));
      end else begin
        a = ((r < 95) ? BASE : 32'h3000_0000) | (32'($urandom_range(0, 3)) << 2);
        as = 1'b1; we = 1'b0; be = 4'h0; addr = a; wdata = 32'h0;
      end
      #1;
      check("rnd_rdata", rdata, m_rdata(as, we, addr));
      tick();
      idle_bus();
      check("rnd_txd", txd, 32'(m_txd()));
    end
    for (int c = 0; c < 400 && (m_active || q.size() != 0); c++) begin
      tick();
      check("drain_txd", txd, 32'(m_txd()));
    end
    check("drain_done", 32'(m_active), 32'h0);
    rd_check("drain_status", BASE + 32'h4, m_status());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
